// File: rtl/l1cache_assoc.sv
// N-way set-associative write-back/write-allocate L1 data cache with tree-PLRU
// replacement, byte-strobed MMIO bypass and whole-cache flush. State updates on negedge.
module l1cache_assoc #(
  parameter int          WAYS      = 2,
  parameter int          SETS      = 256,
  parameter int          LINE_W    = 256,
  parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
  parameter logic [31:0] MMIO_MASK = 32'hF000_0000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              l1_read,
  input  logic              l1_write,
  input  logic              l1_flush,
  input  logic [31:0]       l1_addr,
  input  logic [1:0]        l1_write_type,
  input  logic [31:0]       l1_write_data,
  output logic [31:0]       l1_data_o,
  output logic              stall,
  output logic              l1_mmu_req_read,
  output logic              l1_mmu_req_write,
  output logic [31:0]       l1_mmu_req_addr,
  output logic [LINE_W-1:0] l1_mmu_write_data,
  output logic [3:0]        l1_mmu_write_strb,
  input  logic              mmu_l1_read_done,
  input  logic              mmu_l1_write_done,
  input  logic [LINE_W-1:0] mmu_l1_read_data
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;
  localparam int LVL    = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LVL : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [2:0] {IDLE, WB, REFILL, MMIO_RD, MMIO_WR, FLUSH_SCAN, FLUSH_WB} state_t;

  function automatic logic mmio_addr(input logic [31:0] a);
    return (a & MMIO_MASK) == MMIO_BASE;
  endfunction

  // Tree walk in heap order: each node bit points toward the next victim.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] b);
    int node;
    node = 0;
    for (int l = 0; l < LVL; l++) node = 2 * node + 1 + int'(b[node]);
    return WAY_W'(node - (WAYS - 1));
  endfunction

  function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0] b, input logic [WAY_W-1:0] w);
    logic [PLRU_W-1:0] r;
    logic              dir;
    int                node;
    r    = b;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      dir     = w[LVL-1-l];
      r[node] = ~dir;
      node    = 2 * node + 1 + int'(dir);
    end
    return r;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [1:0] ty,
                                             input logic [1:0] lo, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (ty)
      2'b00:   r = wd;
      2'b01:   if (lo[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      2'b10:   r[lo*8 +: 8] = wd[7:0];
      default: r = old;
    endcase
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] line, input logic [WSEL_W-1:0] wsel,
                                                   input logic [1:0] ty, input logic [1:0] lo, input logic [31:0] wd);
    logic [LINE_W-1:0] r;
    r = line;
    r[wsel*32 +: 32] = merge_word(line[wsel*32 +: 32], ty, lo, wd);
    return r;
  endfunction

  logic [LINE_W-1:0] data_mem [WAYS][SETS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [WAYS-1:0]   valid_reg [SETS];
  logic [WAYS-1:0]   dirty_reg [SETS];
  logic [PLRU_W-1:0] plru_reg  [SETS];

  state_t            state_reg, state_next;
  logic [WAY_W-1:0]  victim_reg, victim_next;
  logic              done_reg, done_next;
  logic [IDX_W-1:0]  flush_set_reg, flush_set_next;
  logic [WAY_W-1:0]  flush_way_reg, flush_way_next;
  logic [31:0]       mmio_data_reg;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [WSEL_W-1:0] a_wsel;
  logic              is_wr, req, is_mmio, noop;
  logic [WAYS-1:0]   hit_vec;
  logic [LINE_W-1:0] rd_line [WAYS];
  logic [WAY_W-1:0]  hit_way, inv_way, victim_way;
  logic              inv_found, flush_last, flush_step, stall_c;
  logic              data_we, tag_we, meta_we, meta_valid, meta_dirty, plru_we, mmio_we;
  logic [WAY_W-1:0]  data_way, meta_way;
  logic [IDX_W-1:0]  meta_set;
  logic [LINE_W-1:0] data_wdata;
  logic [PLRU_W-1:0] plru_val;
  logic [31:0]       mmio_lane;
  logic [3:0]        mmio_strb;

  assign a_tag   = l1_addr[31 -: TAG_W];
  assign a_idx   = l1_addr[OFF_W +: IDX_W];
  assign a_wsel  = l1_addr[OFF_W-1:2];
  assign is_wr   = l1_write;
  assign req     = l1_read | l1_write;
  assign is_mmio = mmio_addr(l1_addr);
  assign noop    = (l1_write_type == 2'b11);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign hit_vec[gi] = valid_reg[a_idx][gi] && (tag_mem[gi][a_idx] == a_tag);
    assign rd_line[gi] = data_mem[gi][a_idx];
  end

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    hit_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_reg[a_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  assign victim_way = inv_found ? inv_way : plru_victim(plru_reg[a_idx]);
  assign flush_last = (flush_set_reg == IDX_W'(SETS - 1)) && (flush_way_reg == WAY_W'(WAYS - 1));

  always_comb begin
    mmio_lane = l1_write_data;
    mmio_strb = 4'hF;
    case (l1_write_type)
      2'b01:   begin mmio_lane = {2{l1_write_data[15:0]}}; mmio_strb = l1_addr[1] ? 4'hC : 4'h3; end
      2'b10:   begin mmio_lane = {4{l1_write_data[7:0]}}; mmio_strb = 4'b0001 << l1_addr[1:0]; end
      default: ;
    endcase
  end

  always_comb begin
    l1_data_o = is_mmio ? mmio_data_reg : rd_line[hit_way][a_wsel*32 +: 32];
  end

  always_comb begin
    state_next = state_reg;  victim_next = victim_reg;  done_next = done_reg;
    flush_set_next = flush_set_reg;  flush_way_next = flush_way_reg;  flush_step = 1'b0;
    stall_c = 1'b0;  l1_mmu_req_read = 1'b0;  l1_mmu_req_write = 1'b0;
    l1_mmu_req_addr = '0;  l1_mmu_write_data = '0;  l1_mmu_write_strb = '0;
    data_we = 1'b0;  tag_we = 1'b0;  data_way = hit_way;  data_wdata = '0;
    meta_we = 1'b0;  meta_set = a_idx;  meta_way = hit_way;  meta_valid = 1'b0;  meta_dirty = 1'b0;
    plru_we = 1'b0;  plru_val = plru_update(plru_reg[a_idx], hit_way);  mmio_we = 1'b0;
    case (state_reg)
      IDLE: begin
        // done_reg marks an MMIO access or flush that finished while its request is still held
        done_next = 1'b0;
        if (l1_flush) begin
          if (!done_reg) begin
            stall_c = 1'b1;  state_next = FLUSH_SCAN;
            flush_set_next = '0;  flush_way_next = '0;
          end
        end else if (req) begin
          if (is_mmio) begin
            if (!(is_wr && noop) && !done_reg) begin
              stall_c    = 1'b1;
              state_next = is_wr ? MMIO_WR : MMIO_RD;
            end
          end else if (|hit_vec) begin
            plru_we = 1'b1;
            if (is_wr && !noop) begin
              data_we    = 1'b1;
              data_wdata = merge_line(rd_line[hit_way], a_wsel, l1_write_type, l1_addr[1:0], l1_write_data);
              meta_we    = 1'b1;  meta_valid = 1'b1;  meta_dirty = 1'b1;
            end
          end else begin
            stall_c     = 1'b1;
            victim_next = victim_way;
            state_next  = (valid_reg[a_idx][victim_way] && dirty_reg[a_idx][victim_way]) ? WB : REFILL;
          end
        end
      end
      WB: begin
        stall_c = 1'b1;  l1_mmu_req_write = 1'b1;  l1_mmu_write_strb = 4'hF;
        l1_mmu_req_addr   = {tag_mem[victim_reg][a_idx], a_idx, {OFF_W{1'b0}}};
        l1_mmu_write_data = rd_line[victim_reg];
        if (mmu_l1_write_done) state_next = REFILL;
      end
      REFILL: begin
        stall_c = 1'b1;  l1_mmu_req_read = 1'b1;
        l1_mmu_req_addr = {l1_addr[31:OFF_W], {OFF_W{1'b0}}};
        if (mmu_l1_read_done) begin
          data_we    = 1'b1;  tag_we = 1'b1;  data_way = victim_reg;
          data_wdata = is_wr ? merge_line(mmu_l1_read_data, a_wsel, l1_write_type, l1_addr[1:0], l1_write_data)
                             : mmu_l1_read_data;
          meta_we = 1'b1;  meta_way = victim_reg;  meta_valid = 1'b1;  meta_dirty = is_wr;
          plru_we = 1'b1;  plru_val = plru_update(plru_reg[a_idx], victim_reg);
          state_next = IDLE;
        end
      end
      MMIO_RD: begin
        stall_c = 1'b1;  l1_mmu_req_read = 1'b1;  l1_mmu_req_addr = {l1_addr[31:2], 2'b00};
        if (mmu_l1_read_done) begin
          mmio_we = 1'b1;  done_next = 1'b1;  state_next = IDLE;
        end
      end
      MMIO_WR: begin
        stall_c = 1'b1;  l1_mmu_req_write = 1'b1;  l1_mmu_req_addr = {l1_addr[31:2], 2'b00};
        l1_mmu_write_data = {{(LINE_W-32){1'b0}}, mmio_lane};
        l1_mmu_write_strb = mmio_strb;
        if (mmu_l1_write_done) begin
          done_next = 1'b1;  state_next = IDLE;
        end
      end
      FLUSH_SCAN: begin
        stall_c = 1'b1;
        if (valid_reg[flush_set_reg][flush_way_reg] && dirty_reg[flush_set_reg][flush_way_reg])
          state_next = FLUSH_WB;
        else
          flush_step = 1'b1;
      end
      FLUSH_WB: begin
        stall_c = 1'b1;  l1_mmu_req_write = 1'b1;  l1_mmu_write_strb = 4'hF;
        l1_mmu_req_addr   = {tag_mem[flush_way_reg][flush_set_reg], flush_set_reg, {OFF_W{1'b0}}};
        l1_mmu_write_data = data_mem[flush_way_reg][flush_set_reg];
        if (mmu_l1_write_done) flush_step = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Retire the current flush entry: invalidate it and advance or finish the scan
    if (flush_step) begin
      meta_we = 1'b1;  meta_set = flush_set_reg;  meta_way = flush_way_reg;
      meta_valid = 1'b0;  meta_dirty = 1'b0;
      if (flush_last) begin
        state_next = IDLE;  done_next = 1'b1;
      end else begin
        state_next = FLUSH_SCAN;
        if (flush_way_reg == WAY_W'(WAYS - 1)) begin
          flush_way_next = '0;
          flush_set_next = flush_set_reg + 1'b1;
        end else begin
          flush_way_next = flush_way_reg + 1'b1;
        end
      end
    end
  end

  assign stall = rst_n & stall_c;

  always_ff @(negedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      victim_reg    <= '0;
      done_reg      <= 1'b0;
      flush_set_reg <= '0;
      flush_way_reg <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        plru_reg[s]  <= '0;
      end
    end else begin
      state_reg     <= state_next;
      victim_reg    <= victim_next;
      done_reg      <= done_next;
      flush_set_reg <= flush_set_next;
      flush_way_reg <= flush_way_next;
      if (meta_we) begin
        valid_reg[meta_set][meta_way] <= meta_valid;
        dirty_reg[meta_set][meta_way] <= meta_dirty;
      end
      if (plru_we) plru_reg[a_idx] <= plru_val;
    end
  end

  always_ff @(negedge sys_clk) begin
    if (data_we) data_mem[data_way][a_idx] <= data_wdata;
    if (tag_we)  tag_mem[data_way][a_idx]  <= a_tag;
    if (mmio_we) mmio_data_reg <= mmu_l1_read_data[31:0];
  end
endmodule

// File: tb/tb_l1cache_assoc.sv
// Directed bench for l1cache_assoc (WAYS=2, SETS=256, LINE_W=256): misses, PLRU,
// store merge, dirty eviction, MMIO bypass, flush and mid-transaction reset.
`timescale 1ns/1ps
module tb_l1cache_assoc;
  localparam int LINE_W = 256;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              l1_read, l1_write, l1_flush;
  logic [31:0]       l1_addr, l1_write_data;
  logic [1:0]        l1_write_type;
  logic [31:0]       l1_data_o;
  logic              stall, l1_mmu_req_read, l1_mmu_req_write;
  logic [31:0]       l1_mmu_req_addr;
  logic [LINE_W-1:0] l1_mmu_write_data;
  logic [3:0]        l1_mmu_write_strb;
  logic              mmu_l1_read_done, mmu_l1_write_done;
  logic [LINE_W-1:0] mmu_l1_read_data;

  int checks = 0;
  int errors = 0;

  l1cache_assoc #(.WAYS(2), .SETS(256), .LINE_W(LINE_W)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .l1_read(l1_read), .l1_write(l1_write), .l1_flush(l1_flush),
    .l1_addr(l1_addr), .l1_write_type(l1_write_type), .l1_write_data(l1_write_data),
    .l1_data_o(l1_data_o), .stall(stall),
    .l1_mmu_req_read(l1_mmu_req_read), .l1_mmu_req_write(l1_mmu_req_write),
    .l1_mmu_req_addr(l1_mmu_req_addr), .l1_mmu_write_data(l1_mmu_write_data),
    .l1_mmu_write_strb(l1_mmu_write_strb),
    .mmu_l1_read_done(mmu_l1_read_done), .mmu_l1_write_done(mmu_l1_write_done),
    .mmu_l1_read_data(mmu_l1_read_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Word k = {hi, k}, except word 1 which is given explicitly
  function automatic logic [LINE_W-1:0] mk_line(input logic [15:0] hi, input logic [31:0] w1);
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = {hi, 16'(k)};
    r[63:32] = w1;
    return r;
  endfunction

  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [1:0] ty, input logic [31:0] wd);
    @(posedge sys_clk);
    l1_read = rd;  l1_write = wr;  l1_addr = a;  l1_write_type = ty;  l1_write_data = wd;
    #1;
  endtask

  task automatic release_req();
    @(posedge sys_clk);
    l1_read = 1'b0;  l1_write = 1'b0;  l1_flush = 1'b0;
    l1_addr = '0;  l1_write_type = 2'b00;  l1_write_data = '0;
  endtask

  // Waits (bounded) for the requested MMU transaction, captures it and answers with one done pulse
  task automatic mmu_serve(input bit wr, input logic [LINE_W-1:0] rdata, output logic [31:0] addr,
                           output logic [LINE_W-1:0] wdata, output logic [3:0] strb, output bit ok);
    ok = 1'b0;  addr = '0;  wdata = '0;  strb = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge sys_clk); #1;
      if ((wr && l1_mmu_req_write) || (!wr && l1_mmu_req_read)) begin
        ok = 1'b1;  addr = l1_mmu_req_addr;  wdata = l1_mmu_write_data;  strb = l1_mmu_write_strb;
      end
    end
    if (ok) begin
      if (wr) mmu_l1_write_done = 1'b1;
      else begin mmu_l1_read_done = 1'b1;  mmu_l1_read_data = rdata; end
      @(posedge sys_clk);
      mmu_l1_write_done = 1'b0;  mmu_l1_read_done = 1'b0;
      #1;
    end
  endtask

  logic [31:0]       cap_addr;
  logic [LINE_W-1:0] cap_data;
  logic [3:0]        cap_strb;
  bit                cap_ok;

  task automatic test_reset();
    rst_n = 1'b0;
    l1_read = 0; l1_write = 0; l1_flush = 0; l1_addr = '0; l1_write_type = '0; l1_write_data = '0;
    mmu_l1_read_done = 0; mmu_l1_write_done = 0; mmu_l1_read_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (stall !== 1'b0 || l1_mmu_req_read !== 1'b0 || l1_mmu_req_write !== 1'b0 ||
        l1_mmu_req_addr !== 32'h0 || l1_mmu_write_strb !== 4'h0 || l1_mmu_write_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b rd=%b wr=%b addr=%h strb=%h, required all zero",
               stall, l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_strb);
    end
    @(posedge sys_clk);
    rst_n = 1'b1;
    $display("reset: checked outputs zero, released");
  endtask

  task automatic test_load_miss();
    req(1, 0, 32'h0000_1004, 2'b00, 0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_miss_stall: got %b required 1", stall); end
    mmu_serve(0, mk_line(16'hA000, 32'hDEAD_BEEF), cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL refill_addr: ok=%b addr=%h required 00001000", cap_ok, cap_addr);
    end
    checks++;
    if (stall !== 1'b0 || l1_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL refill_data: stall=%b data=%h required 0/deadbeef", stall, l1_data_o);
    end
    release_req();
    req(1, 0, 32'h0000_1004, 2'b00, 0);
    checks++;
    if (stall !== 1'b0 || l1_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL repeat_hit: stall=%b data=%h required 0/deadbeef", stall, l1_data_o);
    end
    release_req();
    $display("load_miss: refill 0x1000 then hit at 0x1004");
  endtask

  task automatic test_plru();
    req(1, 0, 32'h0000_3004, 2'b00, 0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL b_miss: stall=%b required 1", stall); end
    mmu_serve(0, mk_line(16'hB000, 32'hB0B0_0001), cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_3000 || l1_data_o !== 32'hB0B0_0001) begin
      errors++; $display("FAIL b_refill: ok=%b addr=%h data=%h required 00003000/b0b00001", cap_ok, cap_addr, l1_data_o);
    end
    release_req();
    req(1, 0, 32'h0000_1004, 2'b00, 0);
    checks++;
    if (stall !== 1'b0 || l1_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL a_reload: stall=%b data=%h required 0/deadbeef", stall, l1_data_o);
    end
    release_req();
    req(1, 0, 32'h0000_5004, 2'b00, 0);
    mmu_serve(0, mk_line(16'hC000, 32'hC0C0_0001), cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_5000 || l1_data_o !== 32'hC0C0_0001) begin
      errors++; $display("FAIL c_refill: ok=%b addr=%h data=%h required 00005000/c0c00001", cap_ok, cap_addr, l1_data_o);
    end
    release_req();
    req(1, 0, 32'h0000_1004, 2'b00, 0);
    checks++;
    if (stall !== 1'b0 || l1_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL a_still_hits: stall=%b data=%h required 0/deadbeef", stall, l1_data_o);
    end
    release_req();
    req(1, 0, 32'h0000_3004, 2'b00, 0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL b_evicted: stall=%b required 1", stall); end
    mmu_serve(0, mk_line(16'hB000, 32'hB0B0_0001), cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL b_rerefill: ok=%b addr=%h required 00003000", cap_ok, cap_addr);
    end
    release_req();
    $display("plru: B evicted by C, A kept");
  endtask

  task automatic test_store_evict();
    req(0, 1, 32'h0000_1004, 2'b00, 32'h1122_3344);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL sw_hit_stall: got %b required 0", stall); end
    release_req();
    req(0, 1, 32'h0000_1006, 2'b10, 32'h0000_00AB);
    release_req();
    req(1, 0, 32'h0000_1004, 2'b00, 0);
    checks++;
    if (l1_data_o !== 32'h11AB_3344) begin errors++; $display("FAIL sb_merge: got %h required 11ab3344", l1_data_o); end
    release_req();
    req(0, 1, 32'h0000_1004, 2'b11, 32'hFFFF_FFFF);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL noop_stall: got %b required 0", stall); end
    release_req();
    req(1, 0, 32'h0000_1004, 2'b00, 0);
    checks++;
    if (l1_data_o !== 32'h11AB_3344) begin errors++; $display("FAIL noop_store: got %h required 11ab3344", l1_data_o); end
    release_req();
    req(1, 0, 32'h0000_3004, 2'b00, 0);
    release_req();
    req(1, 0, 32'h0000_7004, 2'b00, 0);
    mmu_serve(1, '0, cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_1000 || cap_strb !== 4'hF ||
        cap_data[63:32] !== 32'h11AB_3344 || cap_data[31:0] !== 32'hA000_0000) begin
      errors++; $display("FAIL wb_victim: ok=%b addr=%h strb=%h w1=%h w0=%h required 00001000/f/11ab3344/a0000000",
                         cap_ok, cap_addr, cap_strb, cap_data[63:32], cap_data[31:0]);
    end
    mmu_serve(0, mk_line(16'hD000, 32'hD0D0_0001), cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_7000 || l1_data_o !== 32'hD0D0_0001) begin
      errors++; $display("FAIL wb_then_refill: ok=%b addr=%h data=%h required 00007000/d0d00001", cap_ok, cap_addr, l1_data_o);
    end
    release_req();
    req(0, 1, 32'h0000_7006, 2'b01, 32'h0000_BEEF);
    release_req();
    req(1, 0, 32'h0000_7004, 2'b00, 0);
    checks++;
    if (l1_data_o !== 32'hBEEF_0001) begin errors++; $display("FAIL sh_upper: got %h required beef0001", l1_data_o); end
    release_req();
    req(0, 1, 32'h0000_7009, 2'b01, 32'h0000_1234);
    release_req();
    req(1, 0, 32'h0000_7008, 2'b00, 0);
    checks++;
    if (l1_data_o !== 32'hD000_1234) begin errors++; $display("FAIL sh_lower_odd: got %h required d0001234", l1_data_o); end
    release_req();
    $display("store_evict: merged stores, dirty victim written back before refill");
  endtask

  task automatic test_mmio();
    req(0, 1, 32'hF000_0002, 2'b01, 32'h0000_BEEF);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL mmio_sh_stall: got %b required 1", stall); end
    mmu_serve(1, '0, cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'hF000_0000 || cap_strb !== 4'hC || cap_data[31:16] !== 16'hBEEF) begin
      errors++; $display("FAIL mmio_sh: ok=%b addr=%h strb=%h hi=%h required f0000000/c/beef",
                         cap_ok, cap_addr, cap_strb, cap_data[31:16]);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mmio_sh_done: stall=%b required 0", stall); end
    release_req();
    req(0, 1, 32'hF000_0003, 2'b10, 32'h0000_00AB);
    mmu_serve(1, '0, cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_strb !== 4'h8 || cap_data[31:0] !== 32'hABAB_ABAB) begin
      errors++; $display("FAIL mmio_sb: ok=%b strb=%h data=%h required 8/abababab", cap_ok, cap_strb, cap_data[31:0]);
    end
    release_req();
    req(0, 1, 32'hF000_0000, 2'b11, 32'h0);
    checks++;
    if (stall !== 1'b0 || l1_mmu_req_write !== 1'b0) begin
      errors++; $display("FAIL mmio_noop: stall=%b wr=%b required 0/0", stall, l1_mmu_req_write);
    end
    release_req();
    req(1, 0, 32'h0000_7004, 2'b00, 0);
    checks++;
    if (stall !== 1'b0 || l1_data_o !== 32'hBEEF_0001) begin
      errors++; $display("FAIL mmio_no_cache_effect: stall=%b data=%h required 0/beef0001", stall, l1_data_o);
    end
    release_req();
    req(1, 0, 32'hF000_0010, 2'b00, 0);
    mmu_serve(0, {{(LINE_W-32){1'b1}}, 32'h1234_5678}, cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'hF000_0010 || stall !== 1'b0 || l1_data_o !== 32'h1234_5678) begin
      errors++; $display("FAIL mmio_load: ok=%b addr=%h stall=%b data=%h required f0000010/0/12345678",
                         cap_ok, cap_addr, stall, l1_data_o);
    end
    release_req();
    $display("mmio: sh strb C, sb strb 8, no-op store, load latched");
  endtask

  task automatic test_flush();
    logic [31:0] wb_addr [2];
    logic [31:0] wb_word [2];
    int          nwb, cycles;
    bit          done;
    req(0, 1, 32'h0000_2000, 2'b00, 32'hCAFE_F00D);
    mmu_serve(0, mk_line(16'hE000, 32'hE0E0_0001), cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_2000 || l1_data_o !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL store_miss_merge: ok=%b addr=%h data=%h required 00002000/cafef00d", cap_ok, cap_addr, l1_data_o);
    end
    release_req();
    @(posedge sys_clk);
    l1_flush = 1'b1;
    nwb = 0;  cycles = 0;  done = 1'b0;
    wb_addr[0] = '0; wb_addr[1] = '0; wb_word[0] = '0; wb_word[1] = '0;
    for (int i = 0; i < 1200 && !done; i++) begin
      @(posedge sys_clk);
      mmu_l1_write_done = 1'b0;
      #1;
      if (!stall) done = 1'b1;
      else begin
        cycles++;
        if (l1_mmu_req_write) begin
          if (nwb < 2) begin
            wb_addr[nwb] = l1_mmu_req_addr;
            wb_word[nwb] = (nwb == 0) ? l1_mmu_write_data[31:0] : l1_mmu_write_data[63:32];
          end
          nwb++;
          mmu_l1_write_done = 1'b1;
        end
      end
    end
    checks++;
    if (!done || cycles !== 514) begin
      errors++; $display("FAIL flush_length: done=%b stall cycles=%0d required 1/514", done, cycles);
    end
    checks++;
    if (nwb !== 2 || wb_addr[0] !== 32'h0000_2000 || wb_word[0] !== 32'hCAFE_F00D ||
        wb_addr[1] !== 32'h0000_7000 || wb_word[1] !== 32'hBEEF_0001) begin
      errors++; $display("FAIL flush_wb: n=%0d a0=%h w0=%h a1=%h w1=%h required 2/00002000/cafef00d/00007000/beef0001",
                         nwb, wb_addr[0], wb_word[0], wb_addr[1], wb_word[1]);
    end
    release_req();
    req(1, 0, 32'h0000_7004, 2'b00, 0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL post_flush_miss: stall=%b required 1", stall); end
    mmu_serve(0, mk_line(16'hD200, 32'hD2D2_0001), cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_7000 || l1_data_o !== 32'hD2D2_0001) begin
      errors++; $display("FAIL post_flush_refill: ok=%b addr=%h data=%h required 00007000/d2d20001", cap_ok, cap_addr, l1_data_o);
    end
    release_req();
    req(1, 0, 32'h0000_3004, 2'b00, 0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL post_flush_b_miss: stall=%b required 1", stall); end
    mmu_serve(0, mk_line(16'hB000, 32'hB0B0_0001), cap_addr, cap_data, cap_strb, cap_ok);
    release_req();
    $display("flush: %0d write-backs over %0d stall cycles", nwb, cycles);
  endtask

  task automatic test_reset_mid();
    bit seen;
    req(1, 0, 32'h0000_1004, 2'b00, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge sys_clk); #1;
      if (l1_mmu_req_read) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_mid_wait: req_read=%b required 1", l1_mmu_req_read); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (l1_mmu_req_read !== 1'b0 || l1_mmu_req_write !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid: rd=%b wr=%b stall=%b required 0/0/0", l1_mmu_req_read, l1_mmu_req_write, stall);
    end
    release_req();
    @(posedge sys_clk);
    rst_n = 1'b1;
    req(1, 0, 32'h0000_7004, 2'b00, 0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL resident_lost: stall=%b required 1", stall); end
    mmu_serve(0, mk_line(16'hD300, 32'hD3D3_0001), cap_addr, cap_data, cap_strb, cap_ok);
    checks++;
    if (!cap_ok || cap_addr !== 32'h0000_7000 || l1_data_o !== 32'hD3D3_0001) begin
      errors++; $display("FAIL reset_refill: ok=%b addr=%h data=%h required 00007000/d3d30001", cap_ok, cap_addr, l1_data_o);
    end
    release_req();
    $display("reset_mid: request dropped, lines invalidated");
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_plru();
    test_store_evict();
    test_mmio();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
